// File: rtl/im_arbiter.sv
// im_arbiter: round-robin arbiter sharing the image-memory port between the picture engine
// and the clock renderer. Define IMARB_TIMEOUT_EN to force-end bursts longer than MAX_BURST.
module im_arbiter #(
    parameter int MAX_BURST = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pic_req,
    input  logic        cr_req,
    input  logic        pic_last,
    input  logic        cr_last,
    input  logic [19:0] pic_a,
    input  logic [19:0] cr_a,
    input  logic [23:0] pic_d,
    input  logic [23:0] cr_d,
    input  logic        pic_wen,
    input  logic        cr_wen,
    output logic        pic_gnt,
    output logic        cr_gnt,
    output logic [19:0] IM_A,
    output logic [23:0] IM_D,
    output logic        IM_WEN,
    output logic        busy,
    output logic        preempt,
    output logic [1:0]  dbg_state,
    output logic [7:0]  dbg_beats,
    output logic        dbg_at_limit
);
    // Handshake: a requester holds req high while it wants the port. gnt marks every cycle it
    // owns the port; the owner ends its burst by raising last on the final beat or by dropping
    // req (that cycle is still granted). The port is re-arbitrated in the cycle after the end.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_PIC = 2'd1,
        GNT_CR  = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(MAX_BURST - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_owner;
    logic       last_owner_nxt;
    logic [7:0] beats;
    logic [7:0] beats_nxt;
    logic       owner_req;
    logic       owner_last;
    logic       timeout;
    logic       burst_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beats      <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            beats      <= beats_nxt;
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        case (state)
            GNT_PIC: begin
                owner_req  = pic_req;
                owner_last = pic_last;
            end
            GNT_CR: begin
                owner_req  = cr_req;
                owner_last = cr_last;
            end
            default: ;
        endcase
    end

    assign dbg_at_limit = (beats == LIMIT);

`ifdef IMARB_TIMEOUT_EN
    logic other_req;

    always_comb begin
        other_req = 1'b0;
        case (state)
            GNT_PIC: other_req = cr_req;
            GNT_CR:  other_req = pic_req;
            default: ;
        endcase
    end

    // Only a waiting competitor can cut a long burst short.
    assign timeout = busy && dbg_at_limit && other_req;
`else
    assign timeout = 1'b0;
`endif

    assign preempt   = timeout;
    assign burst_end = (state == IDLE) || owner_last || !owner_req || timeout;

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        beats_nxt      = beats;
        if (burst_end) begin
            // On a tie the requester that did not own the port most recently wins.
            state_nxt = IDLE;
            if (pic_req && (!cr_req || last_owner)) begin
                state_nxt = GNT_PIC;
            end else if (cr_req) begin
                state_nxt = GNT_CR;
            end
            if (state_nxt != IDLE) begin
                beats_nxt      = '0;
                last_owner_nxt = (state_nxt == GNT_CR);
            end
        end else if (beats != 8'hFF) begin
            beats_nxt = beats + 8'd1;
        end
    end

    assign pic_gnt = (state == GNT_PIC);
    assign cr_gnt  = (state == GNT_CR);
    assign busy    = pic_gnt || cr_gnt;

    always_comb begin
        IM_A   = '0;
        IM_D   = '0;
        IM_WEN = 1'b1;
        if (pic_gnt) begin
            IM_A   = pic_a;
            IM_D   = pic_d;
            IM_WEN = pic_wen;
        end else if (cr_gnt) begin
            IM_A   = cr_a;
            IM_D   = cr_d;
            IM_WEN = cr_wen;
        end
    end

    assign dbg_state = state;
    assign dbg_beats = beats;

endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: directed and random stimulus for im_arbiter, checked against an owner/beat
// reference model; define IMARB_TIMEOUT_EN to cover the preemption build.
module tb_im_arbiter;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pic_req, cr_req, pic_last, cr_last;
    logic [19:0] pic_a, cr_a;
    logic [23:0] pic_d, cr_d;
    logic        pic_wen, cr_wen;
    logic        pic_gnt, cr_gnt;
    logic [19:0] IM_A;
    logic [23:0] IM_D;
    logic        IM_WEN, busy, preempt;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_beats;
    logic        dbg_at_limit;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port (-1 none, 0 pic, 1 cr), who won last, beats done so far.
    int m_owner;
    int m_last;
    int m_beats;

    always #5 clk = ~clk;

    im_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .pic_req(pic_req), .cr_req(cr_req), .pic_last(pic_last), .cr_last(cr_last),
        .pic_a(pic_a), .cr_a(cr_a), .pic_d(pic_d), .cr_d(cr_d),
        .pic_wen(pic_wen), .cr_wen(cr_wen),
        .pic_gnt(pic_gnt), .cr_gnt(cr_gnt),
        .IM_A(IM_A), .IM_D(IM_D), .IM_WEN(IM_WEN),
        .busy(busy), .preempt(preempt),
        .dbg_state(dbg_state), .dbg_beats(dbg_beats), .dbg_at_limit(dbg_at_limit)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(bit p, bit c, int last);
        if (p && c) return (last == 0) ? 1 : 0;
        if (p) return 0;
        if (c) return 1;
        return -1;
    endfunction

    function automatic bit exp_preempt();
`ifdef IMARB_TIMEOUT_EN
        if (m_owner == 0) return (m_beats == MB - 1) && cr_req;
        if (m_owner == 1) return (m_beats == MB - 1) && pic_req;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_beats = 0;
    endtask

    task automatic drive(bit pr, bit cq, bit pl, bit cl);
        pic_req  = pr;
        cr_req   = cq;
        pic_last = pl;
        cr_last  = cl;
        pic_a    = 20'($urandom());
        cr_a     = 20'($urandom());
        pic_d    = 24'($urandom());
        cr_d     = 24'($urandom());
        pic_wen  = 1'($urandom());
        cr_wen   = 1'($urandom());
    endtask

    task automatic check_cycle(string tag);
        logic [19:0] ea;
        logic [23:0] ed;
        logic        ew;
        ea = '0;
        ed = '0;
        ew = 1'b1;
        if (m_owner == 0) begin
            ea = pic_a; ed = pic_d; ew = pic_wen;
        end else if (m_owner == 1) begin
            ea = cr_a; ed = cr_d; ew = cr_wen;
        end
        chk({tag, ".pic_gnt"}, 32'(pic_gnt), 32'(m_owner == 0));
        chk({tag, ".cr_gnt"}, 32'(cr_gnt), 32'(m_owner == 1));
        chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        chk({tag, ".IM_A"}, 32'(IM_A), 32'(ea));
        chk({tag, ".IM_D"}, 32'(IM_D), 32'(ed));
        chk({tag, ".IM_WEN"}, 32'(IM_WEN), 32'(ew));
        chk({tag, ".preempt"}, 32'(preempt), 32'(exp_preempt()));
        if (m_owner >= 0) chk({tag, ".beats"}, 32'(dbg_beats), 32'(m_beats));
    endtask

    // Called just after a falling edge with inputs applied: check this cycle, advance the model.
    task automatic step(string tag);
        int nxt;
        bit end_b;
        #1;
        check_cycle(tag);
        if (m_owner < 0)       end_b = 1'b1;
        else if (m_owner == 0) end_b = pic_last || !pic_req || exp_preempt();
        else                   end_b = cr_last || !cr_req || exp_preempt();
        if (end_b) begin
            nxt = pick(pic_req, cr_req, m_last);
            if (nxt >= 0) begin
                m_last  = nxt;
                m_beats = 0;
            end
            m_owner = nxt;
        end else if (m_beats < 255) begin
            m_beats++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int idle_cnt;
        int first_pre;
        int pic_cycles;

        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_cycle("reset");
        reset_n = 1'b1;

        // Reset in the middle of a clock-renderer burst drops the grant at once.
        drive(0, 1, 0, 0); step("cr_req");
        drive(0, 1, 0, 0); step("cr_b0");
        drive(1, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid.pic_gnt", 32'(pic_gnt), 32'd0);
        chk("rst_mid.cr_gnt", 32'(cr_gnt), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.IM_WEN", 32'(IM_WEN), 32'd1);
        chk("rst_mid.IM_A", 32'(IM_A), 32'd0);
        chk("rst_mid.IM_D", 32'(IM_D), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // First tie after reset goes to the picture engine, then to the clock renderer.
        drive(1, 1, 0, 0); step("tie_idle");
        #1 chk("tie.pic_first", 32'(pic_gnt), 32'd1);
        drive(1, 1, 1, 0); step("tie_pic_last");
        #1 chk("tie.cr_second", 32'(cr_gnt), 32'd1);
        drive(0, 0, 0, 1); step("tie_cr_last");

        // Single four-beat write burst with fixed address and data.
        drive(1, 0, 0, 0); step("single_req");
        for (int i = 0; i < 4; i++) begin
            drive((i != 3), 0, (i == 3), 0);
            pic_a   = 20'h00010;
            pic_d   = 24'hABCDEF;
            pic_wen = 1'b0;
            #1;
            chk($sformatf("single.IM_A%0d", i), 32'(IM_A), 32'h00010);
            chk($sformatf("single.IM_D%0d", i), 32'(IM_D), 32'hABCDEF);
            chk($sformatf("single.IM_WEN%0d", i), 32'(IM_WEN), 32'd0);
            step($sformatf("single_b%0d", i));
        end
        drive(0, 0, 0, 0);
        #1 chk("single.idle_wen", 32'(IM_WEN), 32'd1);
        step("single_idle");

        // Round-robin with both requesting continuously and three-beat bursts.
        idle_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            drive(1, 1, (m_owner == 0 && m_beats == 2), (m_owner == 1 && m_beats == 2));
            #1;
            if (i > 0 && !busy) idle_cnt++;
            step($sformatf("rr%0d", i));
        end
        chk("rr.no_idle", 32'(idle_cnt), 32'd0);
        drive(0, 0, 0, 0); step("rr_drop");
        drive(0, 0, 0, 0); step("rr_idle");

        // Abort: clock renderer drops req on its third beat while the picture engine waits.
        drive(0, 1, 0, 0); step("abort_req");
        drive(1, 1, 0, 0); step("abort_b0");
        drive(1, 1, 0, 0); step("abort_b1");
        drive(1, 0, 0, 0);
        #1 chk("abort.preempt", 32'(preempt), 32'd0);
        step("abort_b2");
        #1 chk("abort.pic_next", 32'(pic_gnt), 32'd1);

        // Picture engine never raises last while the clock renderer keeps requesting.
        first_pre  = -1;
        pic_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 0, 0);
            #1;
            if (preempt && first_pre < 0) first_pre = i;
            if (pic_gnt) pic_cycles++;
            step($sformatf("hold%0d", i));
        end
`ifdef IMARB_TIMEOUT_EN
        chk("timeout.first_preempt", 32'(first_pre), 32'(MB - 1));
`else
        chk("hold.pic_cycles", 32'(pic_cycles), 32'd100);
        chk("hold.no_preempt", 32'(first_pre), 32'hFFFFFFFF);
`endif
        drive(0, 0, 0, 0); step("hold_drop");
        drive(0, 0, 0, 0); step("hold_idle");

        // Long uncontested burst: beat counter saturates.
        for (int i = 0; i < 270; i++) begin
            drive(1, 0, 0, 0);
            step($sformatf("sat%0d", i));
        end
        chk("sat.beats", 32'(dbg_beats), 32'd255);
        drive(0, 0, 0, 0); step("sat_drop");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            step($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/im_arbiter.md
IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 256, range 2..256: maximum granted cycles per burst when IMARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports pic_req / cr_req, inputs, 1 bit each: picture engine / clock renderer request IM port.
REQ-005 SHALL have ports pic_last / cr_last, inputs, 1 bit each: current granted cycle is the final beat of the burst.
REQ-006 SHALL have ports pic_a / cr_a (input, 20 bits), pic_d / cr_d (input, 24 bits) and pic_wen / cr_wen (input, 1 bit, active-low): requester address, data and write enable.
REQ-007 SHALL have ports pic_gnt / cr_gnt, outputs, 1 bit each: requester owns the IM port in this cycle.
REQ-008 SHALL have ports IM_A (output, 20 bits), IM_D (output, 24 bits) and IM_WEN (output, 1 bit, active-low): image-memory port.
REQ-009 SHALL have port busy, output, 1 bit: a grant is active.
REQ-010 SHALL have port preempt, output, 1 bit: one-cycle pulse when a burst is force-ended.

Function
- REQ-011 FSM SHALL have exactly 3 registered states: IDLE, GNT_PIC, GNT_CR; pic_gnt=(state==GNT_PIC), cr_gnt=(state==GNT_CR), busy=pic_gnt|cr_gnt.
- REQ-012 IM_A/IM_D/IM_WEN SHALL be a combinational mux of the granted requester's a/d/wen; in IDLE: IM_A=0, IM_D=0, IM_WEN=1.
- REQ-013 Grant latency SHALL be exactly 1 cycle: req sampled high in IDLE -> grant asserted next cycle.
- REQ-014 A 1-bit last_owner register SHALL record the most recently granted requester (0=PIC, 1=CR).
- REQ-015 Arbitration (IDLE, or burst end) SHALL be round-robin: if both requesters request, the one not equal to last_owner wins; if only one requests, it wins; if none, go to IDLE.
- REQ-016 Burst end SHALL be the cycle where gnt && last; the next cycle SHALL re-arbitrate, with no IDLE bubble if any request is pending.
- REQ-017 If a granted requester drops req without last, the arbiter SHALL treat the current cycle as an abort: owner's outputs still muxed this cycle, re-arbitrate next cycle.
- REQ-018 A 8-bit beat counter SHALL clear on every new grant and increment each granted cycle, saturating at 255.
- REQ-019 req inputs of a non-granted requester SHALL NOT affect the current grant except via REQ-022.
- REQ-020 Simultaneous last on the owner and req rise on the other SHALL hand over to the other next cycle.

Reset
- REQ-021 On reset_n low, asynchronously: state=IDLE, last_owner=1 (PIC wins the first tie), beat counter=0, preempt=0, all gnt=0, IM_WEN=1, IM_A=0, IM_D=0; reset mid-burst SHALL drop grant immediately.

Configuration
- REQ-022 Macro IMARB_TIMEOUT_EN defined: when beat counter == MAX_BURST-1 and the other requester's req is high, the current cycle SHALL be the final beat, preempt SHALL pulse in that cycle, and the other requester SHALL be granted next cycle.
- REQ-023 Without IMARB_TIMEOUT_EN, a burst SHALL end only on last or req drop, and preempt SHALL be constant 0.

Verification
- REQ-024 Reset: assert reset_n=0 mid-GNT_CR -> gnt both 0, IM_WEN=1, IM_A=0 same cycle; after release, pic_req=cr_req=1 -> pic_gnt=1 after 1 cycle.
- REQ-025 Single burst: pic_req=1, pic_a=20'h00010, pic_d=24'hABCDEF, pic_wen=0 for 4 cycles, pic_last on 4th -> IM_A/IM_D/IM_WEN mirror pic inputs for 4 cycles, then IDLE with IM_WEN=1.
- REQ-026 Round-robin: both req held continuously, each last every 3 beats -> grants alternate PIC,CR,PIC, 3 cycles each, no IDLE cycle between.
- REQ-027 Abort: cr granted, cr_req drops at beat 2 with pic_req=1 -> pic_gnt=1 next cycle, preempt=0.
- REQ-028 Timeout (IMARB_TIMEOUT_EN, MAX_BURST=4): pic never asserts last, cr_req=1 -> preempt=1 on PIC beat 4, cr_gnt=1 next cycle; without the macro PIC keeps grant for 100 cycles.
- REQ-029 Tie after reset: pic_req and cr_req rise same cycle -> PIC granted first; after its last, CR granted.
